// File: rtl/dtlb_refill.sv
// DTLB refill walker: on a DTLB miss, reads one PTE from a single-level page table
// and either fills the DTLB or reports a page fault. All outputs are registered.
module dtlb_refill #(
   parameter int unsigned VPN_W   = 20,
   parameter int unsigned PPN_W   = 8,
   parameter int unsigned PADDR_W = 20,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               miss,
   input  logic [VPN_W-1:0]   miss_vpn,
   input  logic [PADDR_W-1:0] pt_base,
   output logic               mem_req,
   output logic [PADDR_W-1:0] mem_addr,
   input  logic               mem_ack,
   input  logic               mem_rvalid,
   input  logic [31:0]        mem_rdata,
   output logic               write_en,
   output logic [VPN_W-1:0]   write_vpn,
   output logic [PPN_W-1:0]   write_ppn,
   output logic               busy,
   output logic               fault,
   output logic [VPN_W-1:0]   fault_vpn,
   output logic [CNT_W-1:0]   walk_cnt,
   output logic [CNT_W-1:0]   fault_cnt
);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StFill, StFault, StDone} state_e;

   state_e             state_q, state_d;
   logic [VPN_W-1:0]   vpn_q, vpn_d;
   logic               mem_req_q, mem_req_d;
   logic [PADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic               write_en_q, write_en_d;
   logic [VPN_W-1:0]   write_vpn_q, write_vpn_d;
   logic [PPN_W-1:0]   write_ppn_q, write_ppn_d;
   logic               busy_q, busy_d;
   logic               fault_q, fault_d;
   logic [VPN_W-1:0]   fault_vpn_q, fault_vpn_d;
   logic [CNT_W-1:0]   walk_cnt_q, walk_cnt_d;
   logic [CNT_W-1:0]   fault_cnt_q, fault_cnt_d;
   logic [PADDR_W-1:0] pte_off;

   // PTE byte offset; the sum with pt_base wraps modulo 2^PADDR_W
   assign pte_off = PADDR_W'({miss_vpn, 2'b00});

   logic unused_rdata;
   assign unused_rdata = ^mem_rdata[30:PPN_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         vpn_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         write_en_q  <= 1'b0;
         write_vpn_q <= '0;
         write_ppn_q <= '0;
         busy_q      <= 1'b0;
         fault_q     <= 1'b0;
         fault_vpn_q <= '0;
         walk_cnt_q  <= '0;
         fault_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         vpn_q       <= vpn_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         write_en_q  <= write_en_d;
         write_vpn_q <= write_vpn_d;
         write_ppn_q <= write_ppn_d;
         busy_q      <= busy_d;
         fault_q     <= fault_d;
         fault_vpn_q <= fault_vpn_d;
         walk_cnt_q  <= walk_cnt_d;
         fault_cnt_q <= fault_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (miss) state_d = StReq;
         StReq:   if (mem_ack) state_d = StWait;
         StWait:  if (mem_rvalid) state_d = mem_rdata[31] ? StFill : StFault;
         StFill:  state_d = StDone;
         StFault: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Next values of the registered outputs, decided alongside the state transition
   always_comb begin
      vpn_d       = vpn_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      write_en_d  = 1'b0;
      write_vpn_d = write_vpn_q;
      write_ppn_d = write_ppn_q;
      busy_d      = (state_d != StIdle);
      fault_d     = 1'b0;
      fault_vpn_d = fault_vpn_q;
      walk_cnt_d  = walk_cnt_q;
      fault_cnt_d = fault_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (miss) begin
               vpn_d      = miss_vpn;
               mem_addr_d = pt_base + pte_off;
               mem_req_d  = 1'b1;
            end
         end
         StReq: begin
            if (mem_ack) mem_req_d = 1'b0;
         end
         StWait: begin
            if (mem_rvalid) begin
               if (walk_cnt_q != '1) walk_cnt_d = walk_cnt_q + CNT_W'(1);
               if (mem_rdata[31]) begin
                  write_en_d  = 1'b1;
                  write_vpn_d = vpn_q;
                  write_ppn_d = mem_rdata[PPN_W-1:0];
               end else begin
                  fault_d     = 1'b1;
                  fault_vpn_d = vpn_q;
                  if (fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + CNT_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign write_en  = write_en_q;
   assign write_vpn = write_vpn_q;
   assign write_ppn = write_ppn_q;
   assign busy      = busy_q;
   assign fault     = fault_q;
   assign fault_vpn = fault_vpn_q;
   assign walk_cnt  = walk_cnt_q;
   assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_dtlb_refill.sv
// Bench for dtlb_refill: directed walks; expected fills/faults and PTE addresses are
// queued at issue and checked by a monitor when the DUT presents them.
module tb_dtlb_refill;

   localparam int unsigned VPN_W   = 20;
   localparam int unsigned PPN_W   = 8;
   localparam int unsigned PADDR_W = 20;
   localparam int unsigned CNT_W   = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic               miss;
   logic [VPN_W-1:0]   miss_vpn;
   logic [PADDR_W-1:0] pt_base;
   logic               mem_req;
   logic [PADDR_W-1:0] mem_addr;
   logic               mem_ack;
   logic               mem_rvalid;
   logic [31:0]        mem_rdata;
   logic               write_en;
   logic [VPN_W-1:0]   write_vpn;
   logic [PPN_W-1:0]   write_ppn;
   logic               busy;
   logic               fault;
   logic [VPN_W-1:0]   fault_vpn;
   logic [CNT_W-1:0]   walk_cnt;
   logic [CNT_W-1:0]   fault_cnt;

   dtlb_refill #(
      .VPN_W  (VPN_W),
      .PPN_W  (PPN_W),
      .PADDR_W(PADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .miss      (miss),
      .miss_vpn  (miss_vpn),
      .pt_base   (pt_base),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rvalid(mem_rvalid),
      .mem_rdata (mem_rdata),
      .write_en  (write_en),
      .write_vpn (write_vpn),
      .write_ppn (write_ppn),
      .busy      (busy),
      .fault     (fault),
      .fault_vpn (fault_vpn),
      .walk_cnt  (walk_cnt),
      .fault_cnt (fault_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit               flt;
      logic [VPN_W-1:0] vpn;
      logic [PPN_W-1:0] ppn;
      int               cyc;
   } exp_t;

   exp_t               exp_q[$];
   logic [PADDR_W-1:0] addr_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Monitor: pops expectations whenever the DUT accepts a request or emits a fill/fault
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (write_en && fault) check("write_en and fault together", {31'd0, fault}, 32'd0);
         if (mem_req && mem_ack) begin
            if (addr_q.size() == 0) check("unexpected mem accept", addr_q.size(), 1);
            else check("mem_addr at accept", mem_addr, addr_q.pop_front());
         end
         if (write_en || fault) begin
            if (exp_q.size() == 0) begin
               check("unexpected write_en/fault", exp_q.size(), 1);
            end else begin
               x = exp_q.pop_front();
               check("event cycle", cyc, x.cyc);
               if (x.flt) begin
                  check("fault pulse", fault, 1);
                  check("write_en on fault", write_en, 0);
                  check("fault_vpn", fault_vpn, x.vpn);
               end else begin
                  check("write_en pulse", write_en, 1);
                  check("write_vpn", write_vpn, x.vpn);
                  check("write_ppn", write_ppn, x.ppn);
               end
            end
         end
      end
   end

   task automatic do_reset();
      rst        = 1'b1;
      miss       = 1'b0;
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " mem_req"}, mem_req, 0);
      check({tag, " busy"}, busy, 0);
      check({tag, " write_en"}, write_en, 0);
      check({tag, " fault"}, fault, 0);
      check({tag, " mem_addr"}, mem_addr, 0);
      check({tag, " write_vpn"}, write_vpn, 0);
      check({tag, " write_ppn"}, write_ppn, 0);
      check({tag, " fault_vpn"}, fault_vpn, 0);
      check({tag, " walk_cnt"}, walk_cnt, 0);
      check({tag, " fault_cnt"}, fault_cnt, 0);
   endtask

   // One complete walk; ad/rd delay mem_ack and mem_rvalid by that many cycles
   task automatic do_walk(input logic [PADDR_W-1:0] base, input logic [VPN_W-1:0] vpn,
                          input logic [31:0] rdata, input int ad, input int rd,
                          input logic [PADDR_W-1:0] exp_addr);
      exp_t x;
      pt_base  = base;
      miss_vpn = vpn;
      miss     = 1'b1;
      tick();
      miss  = 1'b0;
      x.flt = !rdata[31];
      x.vpn = vpn;
      x.ppn = rdata[PPN_W-1:0];
      x.cyc = cyc + 2 + ad + rd;
      exp_q.push_back(x);
      addr_q.push_back(exp_addr);
      check("busy at walk start", busy, 1);
      for (int i = 0; i < ad; i++) begin
         check("mem_req held", mem_req, 1);
         check("mem_addr held", mem_addr, exp_addr);
         mem_rvalid = 1'b1;  // stray rvalid in REQ, would fault if sampled
         mem_rdata  = '0;
         tick();
         mem_rvalid = 1'b0;
      end
      check("mem_req before ack", mem_req, 1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("mem_req after ack", mem_req, 0);
      for (int i = 0; i < rd; i++) begin
         check("busy in wait", busy, 1);
         tick();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      check("busy in fill/fault", busy, 1);
      tick();
      check("busy in done", busy, 1);
      check("no write_en in done", write_en, 0);
      check("no fault in done", fault, 0);
      tick();
      check("busy back in idle", busy, 0);
   endtask

   initial begin
      exp_t x;
      miss_vpn = '0;
      pt_base  = '0;
      do_reset();
      check_reset_outputs("reset");

      // 1: valid PTE fills the DTLB with minimum latency
      do_walk(20'h10000, 20'h00003, 32'h8000_0042, 0, 0, 20'h1000C);
      check("t1 walk_cnt", walk_cnt, 1);
      check("t1 fault_cnt", fault_cnt, 0);
      check("t1 write_ppn held", write_ppn, 8'h42);

      // 2: invalid PTE faults
      do_reset();
      do_walk(20'h10000, 20'h00003, 32'h0000_0042, 0, 0, 20'h1000C);
      check("t2 walk_cnt", walk_cnt, 1);
      check("t2 fault_cnt", fault_cnt, 1);
      check("t2 fault_vpn held", fault_vpn, 20'h00003);
      check("t2 write_vpn untouched", write_vpn, 0);

      // 3: delayed ack and rvalid
      do_reset();
      do_walk(20'h10000, 20'h12345, 32'h8000_00A5, 3, 2, 20'h58D14);
      check("t3 walk_cnt", walk_cnt, 1);

      // 4: PTE address wraps
      do_walk(20'hFFFF0, 20'h00005, 32'h8000_0077, 0, 0, 20'h00004);
      check("t4 walk_cnt", walk_cnt, 2);

      // 5: miss held through FILL/DONE, new vpn shown in DONE
      do_reset();
      pt_base  = 20'h10000;
      miss_vpn = 20'h00003;
      miss     = 1'b1;
      tick();
      x.flt = 1'b0; x.vpn = 20'h00003; x.ppn = 8'h11; x.cyc = cyc + 2;
      exp_q.push_back(x);
      addr_q.push_back(20'h1000C);
      mem_ack = 1'b1;
      tick();
      mem_ack    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h8000_0011;
      tick();
      mem_rvalid = 1'b0;
      tick();
      miss_vpn = 20'h00007;
      check("t5 busy in done", busy, 1);
      tick();
      check("t5 no request in idle", mem_req, 0);
      check("t5 idle not busy", busy, 0);
      tick();
      check("t5 second walk mem_req", mem_req, 1);
      check("t5 second walk mem_addr", mem_addr, 20'h1001C);
      x.flt = 1'b0; x.vpn = 20'h00007; x.ppn = 8'h22; x.cyc = cyc + 2;
      exp_q.push_back(x);
      addr_q.push_back(20'h1001C);
      miss    = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h8000_0022;
      tick();
      mem_rvalid = 1'b0;
      tick();
      tick();
      check("t5 walk_cnt", walk_cnt, 2);

      // 6: reset in WAIT, then late rvalid
      do_reset();
      pt_base  = 20'h10000;
      miss_vpn = 20'h00009;
      miss     = 1'b1;
      tick();
      miss = 1'b0;
      addr_q.push_back(20'h10024);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      rst     = 1'b1;
      tick();
      check_reset_outputs("t6 in reset");
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h8000_0099;
      tick();
      rst = 1'b0;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      tick();
      tick();
      check_reset_outputs("t6 after stray rvalid");

      check("expectations drained", exp_q.size(), 0);
      check("addresses drained", addr_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
